bus_wide_split_reg: RTL

- Multi-word split register for values wider than one bus word (up to 128 bits); reads and writes carry different data.
- Occupies WORDS consecutive 32-bit addresses.
- Reads are coherent: reading word 0 snapshots the whole input. Writes are atomic: writing the last word commits the whole value to `out`.
- Sits on the local register bus beside the existing single-word registers; bus_out is OR-combined into the bus return path as usual.

---
 rtl/bus_wide_split_reg_pkg.sv | 31 +++
 rtl/bus_wide_split_reg_word_decode.sv | 28 ++
 rtl/bus_wide_split_reg.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_wide_split_reg_pkg.sv
// Shared bus field layout and word-count helpers for multi-word register blocks.
// Optional IRQ support in users of this package is enabled by BUS_WIDE_SPLIT_REG_IRQ_EN.
package bus_wide_split_reg_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 16;
    localparam int unsigned BUS_DATA_WIDTH = 32;

    // bus_in = {reset, we, re, wr_data, addr}
    localparam int unsigned BUS_ADDR_LSB  = 0;
    localparam int unsigned BUS_WDATA_LSB = BUS_ADDR_LSB + BUS_ADDR_WIDTH;
    localparam int unsigned BUS_RE_BIT    = BUS_WDATA_LSB + BUS_DATA_WIDTH;
    localparam int unsigned BUS_WE_BIT    = BUS_RE_BIT + 1;
    localparam int unsigned BUS_RESET_BIT = BUS_WE_BIT + 1;
    localparam int unsigned BUS_IN_WIDTH  = BUS_RESET_BIT + 1;

    // bus_out = {irq, wr_ack, rd_ack, rd_data}
    localparam int unsigned BUS_RDATA_LSB  = 0;
    localparam int unsigned BUS_RD_ACK_BIT = BUS_RDATA_LSB + BUS_DATA_WIDTH;
    localparam int unsigned BUS_WR_ACK_BIT = BUS_RD_ACK_BIT + 1;
    localparam int unsigned BUS_IRQ_BIT    = BUS_WR_ACK_BIT + 1;
    localparam int unsigned BUS_OUT_WIDTH  = BUS_IRQ_BIT + 1;

    function automatic int unsigned bus_word_count(input int unsigned width);
        return (width + BUS_DATA_WIDTH - 1) / BUS_DATA_WIDTH;
    endfunction

    function automatic int unsigned bus_index_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bus_wide_split_reg_word_decode.sv
// Address decoder for a block spanning WORDS consecutive 32-bit words at byte address ADDR.
// Produces a hit flag and the word index within the block; address bits [1:0] are ignored.
module bus_wide_split_reg_word_decode
    import bus_wide_split_reg_pkg::*;
#(
    parameter int unsigned ADDR  = 0,
    parameter int unsigned WORDS = 1,
    localparam int unsigned IW   = bus_index_width(WORDS)
) (
    input  logic [BUS_ADDR_WIDTH-1:0] addr_i,
    output logic                      hit_o,
    output logic [IW-1:0]             idx_o
);

    localparam int unsigned WAW = BUS_ADDR_WIDTH - 2;
    localparam logic [WAW-1:0] BASE = WAW'(ADDR >> 2);
    localparam logic [WAW-1:0] SPAN = WAW'(WORDS);

    logic [WAW-1:0] offset;
    logic           unused_addr;

    // Addresses below the base wrap to large offsets, so one compare covers both bounds.
    assign offset      = addr_i[BUS_ADDR_WIDTH-1:2] - BASE;
    assign hit_o       = offset < SPAN;
    assign idx_o       = offset[IW-1:0];
    assign unused_addr = ^{addr_i[1:0], offset};

endmodule

// File: rtl/bus_wide_split_reg.sv
// Multi-word split register: coherent snapshot reads, shadowed atomic writes committed on the
// last word. Define BUS_WIDE_SPLIT_REG_IRQ_EN to add a sticky input-changed interrupt.
module bus_wide_split_reg
    import bus_wide_split_reg_pkg::*;
#(
    parameter int unsigned          DATAWIDTH = 64,
    parameter int unsigned          WORDS     = bus_word_count(DATAWIDTH),
    parameter logic [DATAWIDTH-1:0] IZ        = '0,
    parameter int unsigned          ADDR      = 0,
    parameter int unsigned          REG       = 0,
    parameter int unsigned          SIZE      = 4 * WORDS
) (
    input  logic                     bus_clk,
    input  logic                     bus_reset,
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    input  logic [DATAWIDTH-1:0]     in,
    output logic [DATAWIDTH-1:0]     out,
    output logic                     wr_pulse
);

    localparam int unsigned  IW   = bus_index_width(WORDS);
    localparam int unsigned  XW   = BUS_DATA_WIDTH * WORDS;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [BUS_DATA_WIDTH-1:0] bus_wr_data;
    logic                      bus_re, bus_we;
    logic                      hit, rd_hit, wr_hit, commit, snap_load;
    logic [IW-1:0]             idx;

    logic [DATAWIDTH-1:0]      snap_q, snap_d, out_q, out_d;
    logic [XW-1:0]             shadow_q, shadow_d;
    logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      rd_ack_q, wr_ack_q, wr_pulse_q;
    logic [XW-1:0]             in_ext, snap_ext, commit_val;
    logic                      irq;
    logic                      unused_sig;

    assign bus_addr    = bus_in[BUS_ADDR_LSB +: BUS_ADDR_WIDTH];
    assign bus_wr_data = bus_in[BUS_WDATA_LSB +: BUS_DATA_WIDTH];
    assign bus_re      = bus_in[BUS_RE_BIT];
    assign bus_we      = bus_in[BUS_WE_BIT];

    bus_wide_split_reg_word_decode #(
        .ADDR  (ADDR),
        .WORDS (WORDS)
    ) u_decode (
        .addr_i (bus_addr),
        .hit_o  (hit),
        .idx_o  (idx)
    );

    assign rd_hit    = bus_re & hit;
    assign wr_hit    = bus_we & hit;
    assign snap_load = rd_hit && (idx == '0);
    assign commit    = wr_hit && (idx == LAST);

    always_comb begin
        in_ext                  = '0;
        in_ext[DATAWIDTH-1:0]   = in;
        snap_ext                = '0;
        snap_ext[DATAWIDTH-1:0] = snap_q;

        rd_data_d = '0;
        if (rd_hit) begin
            if (idx == '0) begin
                rd_data_d = in_ext[BUS_DATA_WIDTH-1:0];
            end else begin
                for (int w = 1; w < int'(WORDS); w++) begin
                    if (idx == IW'(w)) rd_data_d = snap_ext[BUS_DATA_WIDTH*w +: BUS_DATA_WIDTH];
                end
            end
        end

        snap_d = snap_load ? in : snap_q;

        shadow_d = shadow_q;
        for (int w = 0; w < int'(WORDS) - 1; w++) begin
            if (wr_hit && idx == IW'(w)) shadow_d[BUS_DATA_WIDTH*w +: BUS_DATA_WIDTH] = bus_wr_data;
        end

        // The last word comes straight from the bus; lower words from the retained shadow.
        commit_val                         = shadow_q;
        commit_val[XW-1 -: BUS_DATA_WIDTH] = bus_wr_data;
        out_d = commit ? commit_val[DATAWIDTH-1:0] : out_q;
    end

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            out_q      <= IZ;
            snap_q     <= '0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            snap_q     <= snap_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_hit;
            wr_ack_q   <= wr_hit;
            wr_pulse_q <= commit;
        end
    end

`ifdef BUS_WIDE_SPLIT_REG_IRQ_EN
    logic [DATAWIDTH-1:0] in_q;
    logic                 changed_q, changed_d;

    always_comb begin
        changed_d = changed_q;
        if (in_q != snap_q) changed_d = 1'b1;
        // A fresh snapshot acknowledges the change, even if a new one is seen this cycle.
        if (snap_load) changed_d = 1'b0;
    end

    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            in_q      <= '0;
            changed_q <= 1'b0;
        end else begin
            in_q      <= in;
            changed_q <= changed_d;
        end
    end

    assign irq = changed_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        bus_out                                  = '0;
        bus_out[BUS_RDATA_LSB +: BUS_DATA_WIDTH] = rd_data_q;
        bus_out[BUS_RD_ACK_BIT]                  = rd_ack_q;
        bus_out[BUS_WR_ACK_BIT]                  = wr_ack_q;
        bus_out[BUS_IRQ_BIT]                     = irq;
    end

    assign out      = out_q;
    assign wr_pulse = wr_pulse_q;

    assign unused_sig = ^{bus_in[BUS_RESET_BIT], in_ext, commit_val, REG[0], SIZE[0]};

endmodule
